// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM encoding and line constants.
// Kept generic so receive-side blocks can reuse the same encoding.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 frame serializer: loads one byte in IDLE, then drives start, 8 data bits
// (LSB first) and stop on a registered tx line, CLK_DIV clocks per bit.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int  CLK_DIV = 625,
  localparam int DIV_W   = $clog2(CLK_DIV)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [UART_DATA_BITS-1:0] load_data,
  output logic                      tx,
  output uart_state_e               state
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

  uart_state_e               state_d;
  logic [DIV_W-1:0]          div_cnt, div_d;
  logic [2:0]                bit_cnt, bit_d;
  logic [UART_DATA_BITS-1:0] shift, shift_d;
  logic                      tx_d;
  logic                      div_wrap;

  assign div_wrap = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx      <= UART_IDLE_LEVEL;
    end else begin
      state   <= state_d;
      div_cnt <= div_d;
      bit_cnt <= bit_d;
      shift   <= shift_d;
      tx      <= tx_d;
    end
  end

  // tx_d is the level for the next bit period, so tx changes exactly on bit boundaries.
  always_comb begin
    state_d = state;
    div_d   = div_wrap ? '0 : div_cnt + 1'b1;
    bit_d   = bit_cnt;
    shift_d = shift;
    tx_d    = tx;
    unique case (state)
      ST_IDLE: begin
        div_d = '0;
        bit_d = '0;
        tx_d  = UART_IDLE_LEVEL;
        if (load) begin
          shift_d = load_data;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (div_wrap) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shift[0];
        end
      end
      ST_DATA: begin
        if (div_wrap) begin
          if (bit_cnt == BIT_LAST) begin
            state_d = ST_STOP;
            tx_d    = UART_IDLE_LEVEL;
          end else begin
            shift_d = shift >> 1;
            tx_d    = shift[1];
            bit_d   = bit_cnt + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (div_wrap) begin
          state_d = ST_IDLE;
          tx_d    = UART_IDLE_LEVEL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// producers; one 8N1 frame per grant.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  parameter int  CLK_DIV = 625,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id
);

  // Handshake: requester i transfers its byte in the cycle where req_valid[i] &&
  // req_ready[i]; valid may drop before ready (it just leaves arbitration), data
  // is sampled only in the handshake cycle, ready is never held back by rst=0 idle.
  logic [ID_W-1:0]           rr_last;
  logic [ID_W-1:0]           win_idx;
  logic [ID_W-1:0]           cand;
  logic                      win_found;
  logic                      load;
  logic [UART_DATA_BITS-1:0] load_data;
  uart_state_e               ser_state;

  // Scan starts just after the last winner so every pending requester is reached within NUM_REQ-1 frames.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_last) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (ser_state == ST_IDLE && win_found && !rst)
      req_ready[win_idx] = 1'b1;
  end

  assign load      = |(req_valid & req_ready);
  assign load_data = req_data[win_idx*8 +: 8];
  assign busy      = (ser_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last  <= ID_W'(NUM_REQ - 1);
      grant_id <= '0;
    end else if (load) begin
      rr_last  <= win_idx;
      grant_id <= win_idx;
    end
  end

  uart_tx_serializer #(
    .CLK_DIV (CLK_DIV)
  ) u_serializer (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .tx        (tx),
    .state     (ser_state)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: table vectors, directed corner
// sequences and randomized traffic against a frame-level reference model.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = 10 * DIV;
  localparam int MID   = DIV / 2;

  logic         clk;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0] req_ready;
  logic         tx;
  logic         busy;
  logic [1:0]   grant_id;

  uart_tx_arbiter #(.NUM_REQ(N), .CLK_DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int m_busy_left = 0;   // cycles of frame still to run
  int m_rr        = N - 1;
  int m_grant     = 0;
  logic [7:0] exp_q[$];

  bit         dec_active = 0;
  int         dec_cnt    = 0;
  logic [7:0] dec_byte;
  logic [7:0] last_rx    = 8'h00;
  int         rx_count   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: event not seen within bound (cycle %0d)", name, cyc);
  endtask

  // Rotation rule: first valid requester after the last winner, wrapping.
  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (rr + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic int id_of(input logic [N-1:0] h);
    for (int i = 0; i < N; i++) if (h[i]) return i;
    return -1;
  endfunction

  // One clock: apply inputs at negedge, check outputs, advance model.
  task automatic tick(input logic [N-1:0] nv, input logic [8*N-1:0] nd, input logic nr,
                      output logic [N-1:0] hs);
    int       w;
    bit       m_busy;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    rst = nr;
    req_valid = nv;
    req_data = nd;
    #1;
    cyc++;
    m_busy  = (m_busy_left > 0);
    w       = (nr || m_busy) ? -1 : pick(nv, m_rr);
    exp_rdy = (w < 0) ? '0 : (N'(1) << w);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("grant_id", 32'(grant_id), 32'(m_grant));
    if (!m_busy) chk("tx_idle", 32'(tx), 32'd1);

    // mid-bit decoder of the serial line
    if (dec_active) dec_cnt++;
    else if (tx === 1'b0) begin
      dec_active = 1;
      dec_cnt = 0;
    end
    if (dec_active) begin
      if (dec_cnt == MID) chk("start_bit", 32'(tx), 32'd0);
      else if (dec_cnt > MID && dec_cnt < 9*DIV + MID && ((dec_cnt - MID) % DIV) == 0)
        dec_byte[(dec_cnt - MID) / DIV - 1] = tx;
      else if (dec_cnt == 9*DIV + MID) begin
        chk("stop_bit", 32'(tx), 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL rx_unexpected: got frame %0h expected none (cycle %0d)", dec_byte, cyc);
        end else chk("rx_byte", 32'(dec_byte), 32'(exp_q.pop_front()));
        last_rx = dec_byte;
        rx_count++;
        dec_active = 0;
      end
    end

    hs = req_valid & req_ready;
    if (nr) begin
      m_busy_left = 0;
      m_rr = N - 1;
      m_grant = 0;
      dec_active = 0;
      exp_q.delete();
    end else begin
      if (m_busy_left > 0) m_busy_left--;
      if (w >= 0) begin
        m_rr = w;
        m_grant = w;
        m_busy_left = FRAME;
        exp_q.push_back(nd[8*w +: 8]);
      end
    end
  endtask

  task automatic drain(input int n);
    logic [N-1:0] h;
    repeat (n) tick('0, '0, 1'b0, h);
  endtask

  task automatic do_reset();
    logic [N-1:0] h;
    tick('0, '0, 1'b1, h);
    tick('0, '0, 1'b1, h);
  endtask

  task automatic wait_hs(input logic [N-1:0] v, input logic [8*N-1:0] d, output logic [N-1:0] h);
    h = '0;
    for (int t = 0; t < 100 && h == '0; t++) tick(v, d, 1'b0, h);
    if (h == '0) fail("hs_timeout");
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [N-1:0]   valid;
    logic [8*N-1:0] data;
    int             exp_id;
    logic [7:0]     exp_byte;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [N-1:0] hs;
    int ids[5];
    int times[5];
    int n, t0, rx0;
    bit saw_r1;
    logic [N-1:0]   pend;
    logic [8*N-1:0] pdata;

    rst = 1'b1;
    req_valid = '0;
    req_data = '0;

    // Entries run in order from reset, so the expected winners follow the rotation history.
    vecs[0] = '{4'b0100, 32'h00480000, 2, 8'h48};
    vecs[1] = '{4'b1111, 32'h33323130, 3, 8'h33};
    vecs[2] = '{4'b1111, 32'h33323130, 0, 8'h30};
    vecs[3] = '{4'b0011, 32'h00005AA5, 1, 8'h5A};
    vecs[4] = '{4'b0011, 32'h00005AA5, 0, 8'hA5};
    vecs[5] = '{4'b1000, 32'hFF000000, 3, 8'hFF};
    vecs[6] = '{4'b1000, 32'h00000000, 3, 8'h00};
    vecs[7] = '{4'b0110, 32'h007E8100, 1, 8'h81};

    // reset and quiet line
    do_reset();
    drain(100);

    foreach (vecs[i]) begin
      rx0 = rx_count;
      wait_hs(vecs[i].valid, vecs[i].data, hs);
      chk("vec_grant", 32'(id_of(hs)), 32'(vecs[i].exp_id));
      drain(FRAME + 2);
      chk("vec_rx_count", 32'(rx_count - rx0), 32'd1);
      chk("vec_byte", 32'(last_rx), 32'(vecs[i].exp_byte));
    end

    // all four continuously valid: rotation 0,1,2,3,0 at 41-cycle spacing
    do_reset();
    n = 0;
    for (int t = 0; t < 400 && n < 5; t++) begin
      tick(4'b1111, 32'h33323130, 1'b0, hs);
      if (hs != '0) begin
        ids[n] = id_of(hs);
        times[n] = cyc;
        n++;
      end
    end
    if (n < 5) fail("rotation_frames");
    else begin
      for (int j = 0; j < 5; j++) chk("rotation_id", 32'(ids[j]), 32'(j % N));
      for (int j = 1; j < 5; j++) chk("rotation_period", 32'(times[j] - times[j-1]), 32'(FRAME + 1));
    end
    drain(FRAME + 5);

    // lone requester 3 twice back to back
    rx0 = rx_count;
    wait_hs(4'b1000, 32'hC3000000, hs);
    chk("solo_first", 32'(hs), 32'h8);
    t0 = cyc;
    wait_hs(4'b1000, 32'h3C000000, hs);
    chk("solo_second", 32'(hs), 32'h8);
    chk("solo_period", 32'(cyc - t0), 32'(FRAME + 1));
    drain(FRAME + 2);
    chk("solo_rx_count", 32'(rx_count - rx0), 32'd2);
    chk("solo_byte", 32'(last_rx), 32'h3C);

    // reset during data bit 4, then pointer must be back at its reset value
    wait_hs(4'b0001, 32'h00000055, hs);
    chk("pre_abort_grant", 32'(hs), 32'h1);
    repeat (4 * 5 + 1) tick('0, '0, 1'b0, hs);
    chk("abort_busy_before", 32'(busy), 32'd1);
    tick('0, '0, 1'b1, hs);
    tick(4'b0011, 32'h00000B0A, 1'b0, hs);
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("post_reset_grant", 32'(hs), 32'h1);
    drain(FRAME + 2);
    chk("post_reset_byte", 32'(last_rx), 32'h0A);

    // data changed after handshake, and a requester that withdraws before service
    wait_hs(4'b0100, 32'h005C0000, hs);
    chk("sample_grant", 32'(hs), 32'h4);
    saw_r1 = 0;
    repeat (20) begin
      tick(4'b0010, 32'h00A31100, 1'b0, hs);
      saw_r1 |= req_ready[1];
    end
    repeat (FRAME) begin
      tick('0, 32'h00A31100, 1'b0, hs);
      saw_r1 |= req_ready[1];
    end
    chk("sampled_byte", 32'(last_rx), 32'h5C);
    chk("withdrawn_never_ready", 32'(saw_r1), 32'd0);

    // randomized traffic against the model
    do_reset();
    pend = '0;
    pdata = '0;
    for (int t = 0; t < 3000; t++) begin
      logic nr;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 7) == 0) begin
          pend[i] = 1'b1;
          pdata[8*i +: 8] = 8'($urandom);
        end else if (pend[i] && $urandom_range(0, 63) == 0) pend[i] = 1'b0;
      end
      nr = ($urandom_range(0, 999) == 0);
      tick(pend, pdata, nr, hs);
      pend &= ~hs;
      for (int i = 0; i < N; i++)
        if (!pend[i]) pdata[8*i +: 8] = 8'($urandom);
    end
    drain(FRAME + 10);
    chk("random_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
